// File: rtl/buffer_fill_ctrl.sv
// Ring-buffer write/read controller for the parallel-access Buffer.
// Packs PAR_WRITE input elements per write word and tracks committed/reserved occupancy.
module buffer_fill_ctrl #(
    parameter int unsigned SIZE        = 4,
    parameter int unsigned MEM_SIZE    = 4,
    parameter int unsigned PAR_WRITE   = 2,
    parameter int unsigned PAR_READ    = 4,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned ADDRES_SIZE = $clog2(MEM_SIZE),
    parameter int unsigned LW          = $clog2(MEM_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [SIZE-1:0]           in_data,
    output logic                      in_ready,
    output logic                      buf_wen,
    output logic [ADDRES_SIZE-1:0]    buf_waddr,
    output logic [PAR_WRITE*SIZE-1:0] buf_din,
    output logic [ADDRES_SIZE-1:0]    buf_raddr,
    output logic                      rd_valid,
    input  logic                      rd_pop,
    output logic [LW-1:0]             level
);

    localparam int unsigned PCW = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
    localparam int unsigned DW  = PAR_WRITE * SIZE;
    localparam int unsigned AW1 = ADDRES_SIZE + 1;

    localparam logic [PCW-1:0] PC_LAST = PCW'(PAR_WRITE - 1);
    localparam logic [LW-1:0]  L_MEM   = LW'(MEM_SIZE);
    localparam logic [LW-1:0]  L_PW    = LW'(PAR_WRITE);
    localparam logic [LW-1:0]  L_PR    = LW'(PAR_READ);
    localparam logic [LW-1:0]  L_ST    = LW'(STRIDE);

    logic [PCW-1:0] pack_cnt;
    logic [DW-1:0]  pack_q;
    logic [DW-1:0]  pack_nxt;
    logic [LW-1:0]  res;
    logic [LW-1:0]  res_nxt;
    logic [LW-1:0]  level_nxt;
    logic [LW-1:0]  free;
    logic           last_elem;
    logic           accept;
    logic           pack_done;
    logic           pop;

    // Ring pointer advance; subtract-once wrap keeps non-power-of-2 depths correct.
    function automatic logic [ADDRES_SIZE-1:0] wrap_add(input logic [ADDRES_SIZE-1:0] p,
                                                        input int unsigned k);
        logic [AW1-1:0] s;
        s = {1'b0, p} + AW1'(k);
        if (s >= AW1'(MEM_SIZE)) begin
            s = s - AW1'(MEM_SIZE);
        end
        return s[ADDRES_SIZE-1:0];
    endfunction

    // Handshake, lane merge and next occupancy; in_ready sees the pre-update reservation.
    always_comb begin
        free      = L_MEM - res;
        last_elem = (pack_cnt == PC_LAST);
        in_ready  = !last_elem || (free >= L_PW);
        accept    = in_valid && in_ready;
        pack_done = accept && last_elem;
        pop       = rd_pop && rd_valid;

        pack_nxt = pack_q;
        pack_nxt[int'(pack_cnt) * SIZE +: SIZE] = in_data;

        level_nxt = level + (buf_wen ? L_PW : LW'(0)) - (pop ? L_ST : LW'(0));
        res_nxt   = res + (pack_done ? L_PW : LW'(0)) - (pop ? L_ST : LW'(0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_cnt  <= '0;
            pack_q    <= '0;
            buf_wen   <= 1'b0;
            buf_din   <= '0;
            buf_waddr <= '0;
            buf_raddr <= '0;
            level     <= '0;
            res       <= '0;
            rd_valid  <= 1'b0;
        end else begin
            buf_wen <= pack_done;
            if (accept) begin
                if (last_elem) begin
                    pack_cnt <= '0;
                    buf_din  <= pack_nxt;
                end else begin
                    pack_cnt <= pack_cnt + PCW'(1);
                    pack_q   <= pack_nxt;
                end
            end
            // Write address moves only once the word has actually landed.
            if (buf_wen) begin
                buf_waddr <= wrap_add(buf_waddr, PAR_WRITE);
            end
            if (pop) begin
                buf_raddr <= wrap_add(buf_raddr, STRIDE);
            end
            level    <= level_nxt;
            res      <= res_nxt;
            rd_valid <= (level_nxt >= L_PR);
        end
    end

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Bench for buffer_fill_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic on two parameterizations against an occupancy/pointer model.
module tb_buffer_fill_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance 0: defaults (PAR_READ=4); instance 1: PAR_READ=2 so pops can overlap writes.
    logic       rst1, v1, pop1, rdy1, wen1, rv1;
    logic [3:0] d1;
    logic [1:0] wa1, ra1;
    logic [7:0] din1;
    logic [2:0] lvl1;

    logic       rst2, v2, pop2, rdy2, wen2, rv2;
    logic [3:0] d2;
    logic [1:0] wa2, ra2;
    logic [7:0] din2;
    logic [2:0] lvl2;

    buffer_fill_ctrl u_dut1 (
        .clk(clk), .rst(rst1), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .buf_wen(wen1), .buf_waddr(wa1), .buf_din(din1), .buf_raddr(ra1),
        .rd_valid(rv1), .rd_pop(pop1), .level(lvl1)
    );

    buffer_fill_ctrl #(.PAR_READ(2)) u_dut2 (
        .clk(clk), .rst(rst2), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
        .buf_wen(wen2), .buf_waddr(wa2), .buf_din(din2), .buf_raddr(ra2),
        .rd_valid(rv2), .rd_pop(pop2), .level(lvl2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, want);
        end
    endtask

    typedef struct {
        logic       rst, v;
        logic [3:0] d;
        logic       pop;
        logic       rdy, wen;
        logic [1:0] wa;
        logic [7:0] din;
        logic [1:0] ra;
        logic       rv;
        logic [2:0] lvl;
    } vec_t;

    vec_t tbl[21];

    task automatic drv1(input logic r, input logic v, input logic [3:0] d, input logic p);
        @(posedge clk); #1;
        rst1 = r; v1 = v; d1 = d; pop1 = p;
        @(negedge clk);
    endtask

    task automatic drv2(input logic v, input logic [3:0] d, input logic p);
        @(posedge clk); #1;
        rst2 = 1'b0; v2 = v; d2 = d; pop2 = p;
        @(negedge clk);
    endtask

    // Model: counts of words written/popped; pointers and occupancy derive from them.
    int m_pcnt[2], m_wen[2], m_wr[2], m_pp[2], m_din[2], m_lane0[2];
    int m_pr[2] = '{4, 2};

    function automatic int m_level(input int i);
        return m_wr[i] - m_pp[i];
    endfunction

    function automatic int m_rdy(input int i);
        int res;
        res = m_level(i) + 2 * m_wen[i];
        return ((m_pcnt[i] != 1) || (4 - res >= 2)) ? 1 : 0;
    endfunction

    function automatic int m_rv(input int i);
        return (m_level(i) >= m_pr[i]) ? 1 : 0;
    endfunction

    task automatic m_reset(input int i);
        m_pcnt[i] = 0; m_wen[i] = 0; m_wr[i] = 0; m_pp[i] = 0; m_din[i] = 0; m_lane0[i] = 0;
    endtask

    task automatic m_step(input int i, input logic r, input logic v, input logic [3:0] d,
                          input logic p);
        int acc, pp;
        if (r) begin
            m_reset(i);
            return;
        end
        acc = (v && m_rdy(i) != 0) ? 1 : 0;
        pp  = (p && m_rv(i) != 0) ? 1 : 0;
        if (m_wen[i] != 0) begin
            m_wr[i] += 2;
            m_wen[i] = 0;
        end
        if (pp != 0) m_pp[i] += 1;
        if (acc != 0) begin
            if (m_pcnt[i] == 1) begin
                m_din[i]  = int'(d) * 16 + m_lane0[i];
                m_wen[i]  = 1;
                m_pcnt[i] = 0;
            end else begin
                m_lane0[i] = int'(d);
                m_pcnt[i]  = 1;
            end
        end
    endtask

    task automatic m_check(input int i, input logic rdy, input logic wen, input logic [1:0] wa,
                           input logic [7:0] din, input logic [1:0] ra, input logic rv,
                           input logic [2:0] lvl);
        string p;
        p = (i == 0) ? "rnd0" : "rnd1";
        chk({p, ".in_ready"}, 32'(rdy), 32'(m_rdy(i)));
        chk({p, ".buf_wen"},  32'(wen), 32'(m_wen[i]));
        chk({p, ".buf_waddr"}, 32'(wa), 32'(m_wr[i] % 4));
        chk({p, ".buf_din"},  32'(din), 32'(m_din[i]));
        chk({p, ".buf_raddr"}, 32'(ra), 32'(m_pp[i] % 4));
        chk({p, ".rd_valid"}, 32'(rv), 32'(m_rv(i)));
        chk({p, ".level"},    32'(lvl), 32'(m_level(i)));
    endtask

    initial begin
        // rst, v, d, pop | rdy, wen, waddr, din, raddr, rd_valid, level
        tbl[0]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h75, 2'd0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h75, 2'd0, 1'b0, 3'd2};
        tbl[4]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[5]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[6]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 2'd0, 8'h21, 2'd0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 2'd2, 8'h21, 2'd0, 1'b0, 3'd2};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h43, 2'd0, 1'b0, 3'd2};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h43, 2'd0, 1'b1, 3'd4};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h43, 2'd1, 1'b0, 3'd3};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h43, 2'd1, 1'b0, 3'd3};
        tbl[12] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h43, 2'd1, 1'b0, 3'd3};
        tbl[13] = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h43, 2'd1, 1'b0, 3'd3};
        tbl[14] = '{1'b1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd0, 8'h43, 2'd1, 1'b0, 3'd3};
        tbl[15] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[16] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[17] = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[18] = '{1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0, 3'd0};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h86, 2'd0, 1'b0, 3'd0};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2, 8'h86, 2'd0, 1'b0, 3'd2};

        rst1 = 1'b1; v1 = 1'b0; d1 = '0; pop1 = 1'b0;
        rst2 = 1'b1; v2 = 1'b0; d2 = '0; pop2 = 1'b0;
        drv1(1'b1, 1'b0, 4'h0, 1'b0);
        drv1(1'b1, 1'b0, 4'h0, 1'b0);
        rst2 = 1'b0;
        drv1(1'b0, 1'b0, 4'h0, 1'b0);
        chk("reset.in_ready", 32'(rdy1), 32'd1);
        chk("reset.buf_wen", 32'(wen1), 32'd0);
        chk("reset.buf_din", 32'(din1), 32'd0);
        chk("reset.level", 32'(lvl1), 32'd0);
        chk("reset.rd_valid", 32'(rv1), 32'd0);

        for (int i = 0; i < 21; i++) begin
            drv1(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].pop);
            chk($sformatf("vec%0d.in_ready", i), 32'(rdy1), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d.buf_wen", i), 32'(wen1), 32'(tbl[i].wen));
            chk($sformatf("vec%0d.buf_waddr", i), 32'(wa1), 32'(tbl[i].wa));
            chk($sformatf("vec%0d.buf_din", i), 32'(din1), 32'(tbl[i].din));
            chk($sformatf("vec%0d.buf_raddr", i), 32'(ra1), 32'(tbl[i].ra));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rv1), 32'(tbl[i].rv));
            chk($sformatf("vec%0d.level", i), 32'(lvl1), 32'(tbl[i].lvl));
        end

        // Fill to full, then backpressure on the final element of a pack.
        drv2(1'b1, 4'h1, 1'b0);
        drv2(1'b1, 4'h2, 1'b0);
        drv2(1'b1, 4'h3, 1'b0);
        drv2(1'b1, 4'h4, 1'b0);
        drv2(1'b0, 4'h0, 1'b0);
        drv2(1'b1, 4'h9, 1'b0);
        chk("full.level", 32'(lvl2), 32'd4);
        chk("full.waddr", 32'(wa2), 32'd0);
        drv2(1'b1, 4'ha, 1'b0);
        chk("bp.in_ready0", 32'(rdy2), 32'd0);
        drv2(1'b1, 4'ha, 1'b1);
        chk("bp.in_ready1", 32'(rdy2), 32'd0);
        drv2(1'b1, 4'ha, 1'b1);
        chk("bp.level3", 32'(lvl2), 32'd3);
        chk("bp.raddr1", 32'(ra2), 32'd1);
        chk("bp.in_ready2", 32'(rdy2), 32'd0);
        drv2(1'b1, 4'ha, 1'b0);
        chk("bp.level2", 32'(lvl2), 32'd2);
        chk("bp.in_ready3", 32'(rdy2), 32'd1);
        drv2(1'b0, 4'h0, 1'b0);
        chk("bp.wen", 32'(wen2), 32'd1);
        chk("bp.waddr", 32'(wa2), 32'd0);
        chk("bp.din", 32'(din2), 32'h0A9);
        // Read pointer wrap 3 -> 0.
        drv2(1'b0, 4'h0, 1'b1);
        chk("wrap.level", 32'(lvl2), 32'd4);
        chk("wrap.raddr2", 32'(ra2), 32'd2);
        drv2(1'b0, 4'h0, 1'b1);
        chk("wrap.raddr3", 32'(ra2), 32'd3);
        drv2(1'b1, 4'h5, 1'b0);
        chk("wrap.raddr0", 32'(ra2), 32'd0);
        chk("wrap.level2", 32'(lvl2), 32'd2);
        // Pop in the same cycle as a write commit.
        drv2(1'b1, 4'h6, 1'b0);
        drv2(1'b0, 4'h0, 1'b1);
        chk("sim.wen", 32'(wen2), 32'd1);
        chk("sim.rd_valid", 32'(rv2), 32'd1);
        drv2(1'b1, 4'h7, 1'b0);
        chk("sim.level", 32'(lvl2), 32'd3);
        chk("sim.raddr", 32'(ra2), 32'd1);
        chk("sim.waddr", 32'(wa2), 32'd0);
        drv2(1'b1, 4'h8, 1'b1);
        chk("sim.stall_with_pop", 32'(rdy2), 32'd0);
        drv2(1'b1, 4'h8, 1'b0);
        chk("sim.ready_after_pop", 32'(rdy2), 32'd1);
        drv2(1'b0, 4'h0, 1'b0);
        chk("sim.din", 32'(din2), 32'h087);
        chk("sim.waddr2", 32'(wa2), 32'd0);

        // Randomized traffic on both instances against the model.
        @(posedge clk); #1;
        rst1 = 1'b1; rst2 = 1'b1; v1 = 1'b0; v2 = 1'b0; pop1 = 1'b0; pop2 = 1'b0;
        m_reset(0);
        m_reset(1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst1 = ($urandom_range(0, 79) == 0);
            rst2 = ($urandom_range(0, 79) == 0);
            v1 = ($urandom_range(0, 9) < 7);
            v2 = ($urandom_range(0, 9) < 7);
            d1 = 4'($urandom);
            d2 = 4'($urandom);
            pop1 = ($urandom_range(0, 9) < 4);
            pop2 = ($urandom_range(0, 9) < 5);
            @(negedge clk);
            m_check(0, rdy1, wen1, wa1, din1, ra1, rv1, lvl1);
            m_check(1, rdy2, wen2, wa2, din2, ra2, rv2, lvl2);
            m_step(0, rst1, v1, d1, pop1);
            m_step(1, rst2, v2, d2, pop2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
